data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Sequencing controller and arbiter for the byte-wide data memory. It shares the data memory between the core load/store stage and a byte-wide debug/loader port. Each RV32 load or store (byte, halfword or word) is split into one single-byte access per cycle, with little-endian ordering. Loads are sign- or zero-extended according to funct3. Completion is reported with a one-cycle `ready` pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: byte-address width of the data memory (64 bytes).

Ports:
- `clk`  in  1  single clock; all logic on the posedge.
- `rst`  in  1  synchronous reset, active-high.
- `c_req`  in  1  core request; held high until `c_ready` is sampled.
- `c_we`  in  1  1 = store, 0 = load.
- `c_funct3`  in  3  RV32 load/store funct3.
- `c_addr`  in  32  byte address; bits above `ADDR_WIDTH-1` ignored.
- `c_wdata`  in  32  store data; LSB byte goes to the lowest address.
- `c_ready`  out  1  one-cycle completion pulse.
- `c_rdata`  out  32  extended load result; valid while `c_ready`=1.
- `c_err`  out  1  misaligned or illegal access; valid while `c_ready`=1.
- `d_req`  in  1  debug request, single byte.
- `d_we`  in  1  debug write enable.
- `d_addr`  in  `ADDR_WIDTH`  debug byte address.
- `d_wdata`  in  8  debug write byte.
- `d_ready`  out  1  one-cycle completion pulse.
- `d_rdata`  out  8  debug read byte; valid while `d_ready`=1.
- `mem_addr`  out  `ADDR_WIDTH`  memory byte address.
- `mem_we`  out  1  memory byte write strobe.
- `mem_wdata`  out  8  memory write byte.
- `mem_rdata`  in  8  memory read byte; the memory has a registered read with 1-cycle latency.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Reset:** state IDLE, byte counter 0, `last_grant` = debug. All outputs are 0.
- **States:** IDLE → XFER → RESP → IDLE. An error takes the shortcut IDLE → RESP.
- **IDLE:** requests are sampled only here.
  - Arbitration is round-robin. A lone requester wins. On a tie, the requester not named by `last_grant` wins, so after reset the core wins the first tie.
  - On grant, the controller latches the winning requester's fields, updates `last_grant`, and enters XFER with k=0.
  - Requests arriving in any other state are ignored until the next IDLE.
- **Access size N:** set by funct3[1:0]: 00 → 1 byte, 01 → 2 bytes, 10 → 4 bytes. Debug accesses are always N=1.
- **Legal core funct3 values:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value is illegal.
- **Alignment:** the address must be N-aligned. A misaligned or illegal access goes straight to RESP with `c_err`=1 and `c_rdata`=0. No memory strobe is issued.
- **XFER, cycle k (0..N-1):**
  - `mem_addr` = base+k, computed modulo 2^`ADDR_WIDTH`.
  - `mem_we` = we.
  - `mem_wdata` = wdata byte k.
  - For loads, `mem_rdata` returned for byte k-1 is captured into assembly byte k-1.
  - After k=N-1, go to RESP.
- **RESP:**
  - For loads, the final byte is captured.
  - For core loads, the result is extended: funct3 000/001 sign-extend from bit 7/15; 100/101 zero-extend; 010 is the full word.
  - The granted port's `ready` pulses, with `rdata`/`err` valid in the same cycle.
  - Next state is IDLE.
- **Idle outputs:** `mem_we`=0 and `mem_addr` holds its last value. Outside RESP, `c_rdata`, `d_rdata` and `c_err` are 0.

## Timing
- Request sampled at IDLE cycle t → `ready` at cycle t+1+N.
  - Byte: t+2. Halfword: t+3. Word: t+5.
  - Error: t+1.
- A requester must deassert `req` on the edge where it samples `ready`=1. If `req` is still high in the following IDLE cycle, a new transaction starts.
- Minimum spacing between grants is N+2 cycles.
- `rst` asserted mid-transaction aborts it: no `ready` pulse, and `mem_we`=0 from the next cycle. Bytes already written stay written.
- `mem_we` is never high in IDLE or RESP.

## Configuration
- **`DMC_DEBUG_PORT_EN` defined:** the debug port and round-robin arbitration operate as above.
- **`DMC_DEBUG_PORT_EN` undefined:**
  - `d_req`, `d_we`, `d_addr` and `d_wdata` are ignored.
  - `d_ready` and `d_rdata` are tied to 0.
  - The core is granted whenever `c_req`=1 in IDLE.
  - `last_grant` logic is removed.
  - Core timing is unchanged.

## Test plan
- **Core word store then load:** SW 0xDEADBEEF at address 0x08 → `mem_we` high for 4 cycles writing bytes EF, BE, AD, DE at 0x08–0x0B. Then LW 0x08 → `c_ready` at t+5 with `c_rdata`=0xDEADBEEF.
- **Sign/zero extension:** SB 0x80 at 0x03. LB 0x03 → 0xFFFFFF80. LBU 0x03 → 0x00000080. LH 0x02 after SH 0x8001 → 0xFFFF8001.
- **Errors:** LW at 0x06 → `c_err`=1 at t+1, `c_rdata`=0, no `mem_we`. funct3=011 → same response. Store with funct3=100 → same response.
- **Arbitration:** `c_req` and `d_req` asserted together and held for repeated transactions → the core is granted first and grants then alternate core/debug. Each debug write/read completes with `d_ready` at t+2.
- **Reset mid-operation:** assert `rst` during XFER k=1 of a SW → no `c_ready`, `busy`=0 and `mem_we`=0 after the next edge, and the next request behaves normally.
- **Address wrap:** LB at `c_addr`=0x40 with `ADDR_WIDTH`=6 → `mem_addr`=0x00. Build without `DMC_DEBUG_PORT_EN`: `d_req` held high → `d_ready` never asserts.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Sequencing controller and arbiter for a byte-wide data memory shared between
// the core load/store stage and a byte-wide debug/loader port. Each RV32 load
// or store (byte, halfword, word) becomes one single-byte memory access per
// cycle, in little-endian order. Core loads are sign- or zero-extended from
// funct3. Completion is a one-cycle ready pulse on the granted port.
//
// Build option:
//   DMC_DEBUG_PORT_EN  defined   -> debug port active, round-robin arbitration
//                      undefined -> debug inputs ignored, d_ready/d_rdata = 0,
//                                   core granted whenever c_req is high in IDLE
//
// Handshake: a requester raises req and holds it (with its fields stable)
// until it samples ready=1, and drops req on that same edge. Requests are
// only sampled in IDLE; a req still high in the IDLE cycle after ready
// starts a new transaction.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   c_req/c_we/c_funct3 core request, store flag, RV32 load/store funct3
//   c_addr/c_wdata      core byte address (upper bits ignored), store data
//   c_ready/c_rdata     core completion pulse, extended load result
//   c_err               misaligned or illegal access (valid with c_ready)
//   d_req/d_we          debug single-byte request and write enable
//   d_addr/d_wdata      debug byte address and write byte
//   d_ready/d_rdata     debug completion pulse and read byte
//   mem_addr/mem_we     memory byte address and write strobe
//   mem_wdata           memory write byte
//   mem_rdata           memory read byte (registered read, 1-cycle latency)
//   busy                high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [2:0]            c_funct3,
  input  logic [31:0]           c_addr,
  input  logic [31:0]           c_wdata,
  output logic                  c_ready,
  output logic [31:0]           c_rdata,
  output logic                  c_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [7:0]            d_wdata,
  output logic                  d_ready,
  output logic [7:0]            d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched transaction
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [31:0]           wdata_q;
  logic                  gnt_dbg_q;   // 1 = current transaction belongs to debug
  logic                  err_q;
  logic [1:0]            last_k_q;    // N-1 for the current access
  logic [1:0]            k_q;         // byte counter within XFER
  logic [7:0]            asm_q [0:2]; // captured load bytes 0..2
  logic [ADDR_WIDTH-1:0] addr_hold_q; // mem_addr holds its last value when idle

  // Arbitration
  logic core_sel;
  logic dbg_sel;

  // Core request decode
  logic       c_legal;
  logic       c_aligned;
  logic       c_err_d;
  logic [1:0] c_last_k;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            b0, b1, b2, b3;
  logic [31:0]           load_ext;

`ifdef DMC_DEBUG_PORT_EN
  logic last_dbg_q; // last_grant: 1 = debug, 0 = core

  // Tie goes to whichever requester was not granted last.
  always_comb begin
    core_sel = c_req && (!d_req || last_dbg_q);
    dbg_sel  = d_req && !core_sel;
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^{d_req, d_we, d_addr, d_wdata};

  always_comb begin
    core_sel = c_req;
    dbg_sel  = 1'b0;
  end
`endif

  always_comb begin
    c_legal   = 1'b0;
    c_aligned = 1'b0;
    c_last_k  = 2'd0;
    if (c_we) begin
      c_legal = (c_funct3 == 3'b000) || (c_funct3 == 3'b001) ||
                (c_funct3 == 3'b010);
    end else begin
      c_legal = (c_funct3 == 3'b000) || (c_funct3 == 3'b001) ||
                (c_funct3 == 3'b010) || (c_funct3 == 3'b100) ||
                (c_funct3 == 3'b101);
    end
    case (c_funct3[1:0])
      2'b00: begin c_aligned = 1'b1;                 c_last_k = 2'd0; end
      2'b01: begin c_aligned = !c_addr[0];           c_last_k = 2'd1; end
      2'b10: begin c_aligned = (c_addr[1:0] == 2'b00); c_last_k = 2'd3; end
      default: begin c_aligned = 1'b0;               c_last_k = 2'd0; end
    endcase
    c_err_d = !c_legal || !c_aligned;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (core_sel) begin
          state_d = c_err_d ? S_RESP : S_XFER;
        end else if (dbg_sel) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (k_q == last_k_q) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign cur_addr = base_q + ADDR_WIDTH'(k_q);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      wdata_q     <= '0;
      gnt_dbg_q   <= 1'b0;
      err_q       <= 1'b0;
      last_k_q    <= 2'd0;
      k_q         <= 2'd0;
      addr_hold_q <= '0;
      for (int i = 0; i < 3; i++) asm_q[i] <= 8'h00;
`ifdef DMC_DEBUG_PORT_EN
      last_dbg_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          k_q <= 2'd0;
          if (core_sel) begin
            base_q    <= c_addr[ADDR_WIDTH-1:0];
            we_q      <= c_we;
            f3_q      <= c_funct3;
            wdata_q   <= c_wdata;
            gnt_dbg_q <= 1'b0;
            err_q     <= c_err_d;
            last_k_q  <= c_last_k;
`ifdef DMC_DEBUG_PORT_EN
            last_dbg_q <= 1'b0;
          end else if (dbg_sel) begin
            base_q     <= d_addr;
            we_q       <= d_we;
            f3_q       <= 3'b100;
            wdata_q    <= {24'h0, d_wdata};
            gnt_dbg_q  <= 1'b1;
            err_q      <= 1'b0;
            last_k_q   <= 2'd0;
            last_dbg_q <= 1'b1;
`endif
          end
        end
        S_XFER: begin
          k_q         <= k_q + 2'd1;
          addr_hold_q <= cur_addr;
          // Registered memory read: data for byte k-1 arrives during cycle k.
          if (k_q != 2'd0) asm_q[k_q - 2'd1] <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Final byte of a load arrives during RESP and is used directly.
  always_comb begin
    b0 = (last_k_q == 2'd0) ? mem_rdata : asm_q[0];
    b1 = (last_k_q == 2'd1) ? mem_rdata : asm_q[1];
    b2 = asm_q[2];
    b3 = mem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{b0[7]}}, b0};
      3'b001:  load_ext = {{16{b1[7]}}, b1, b0};
      3'b010:  load_ext = {b3, b2, b1, b0};
      3'b100:  load_ext = {24'h0, b0};
      3'b101:  load_ext = {16'h0, b1, b0};
      default: load_ext = 32'h0;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_addr  = (state_q == S_XFER) ? cur_addr : addr_hold_q;
    mem_we    = (state_q == S_XFER) && we_q;
    mem_wdata = (state_q == S_XFER) ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;
    c_ready   = (state_q == S_RESP) && !gnt_dbg_q;
    c_err     = (state_q == S_RESP) && !gnt_dbg_q && err_q;
    c_rdata   = ((state_q == S_RESP) && !gnt_dbg_q && !err_q && !we_q) ?
                load_ext : 32'h0;
`ifdef DMC_DEBUG_PORT_EN
    d_ready   = (state_q == S_RESP) && gnt_dbg_q;
    d_rdata   = ((state_q == S_RESP) && gnt_dbg_q && !we_q) ? mem_rdata : 8'h00;
`else
    d_ready   = 1'b0;
    d_rdata   = 8'h00;
`endif
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  localparam int AW = 6;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          c_req = 0, c_we = 0;
  logic [2:0]    c_funct3 = 0;
  logic [31:0]   c_addr = 0, c_wdata = 0;
  logic          c_ready, c_err;
  logic [31:0]   c_rdata;
  logic          d_req = 0, d_we = 0;
  logic [AW-1:0] d_addr = 0;
  logic [7:0]    d_wdata = 0;
  logic          d_ready;
  logic [7:0]    d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] fa;

  data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_funct3(c_funct3), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_ready(c_ready), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Byte memory with registered read
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b010:  return v;
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Drives one core request and scoreboards its response.
  task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [32:0] exp, input string name,
                         output logic [AW-1:0] first_addr);
    int edges, writes, exp_lat, exp_writes;
    logic got, first;
    logic [32:0] e;
    exp_lat    = exp[32] ? 1 : (f3[1:0] == 2'b00 ? 2 : (f3[1:0] == 2'b01 ? 3 : 5));
    exp_writes = (we && !exp[32]) ? exp_lat - 1 : 0;
    exp_q.push_back(exp);
    @(negedge clk);
    c_req = 1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wd;
    edges = 0; writes = 0; got = 0; first = 1; first_addr = '0;
    while (!got && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (first) begin first_addr = mem_addr; first = 0; end
      if (mem_we) writes++;
      if (c_ready) begin got = 1; c_req = 0; end
    end
    e = exp_q.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++;
      c_req = 0;
      $display("FAIL %s timeout: no c_ready within %0d cycles", name, edges);
    end else begin
      if (c_err !== e[32] || (!we && c_rdata !== e[31:0])) begin
        n_fail++;
        $display("FAIL %s data: got err=%b rdata=%h, expected err=%b rdata=%h",
                 name, c_err, c_rdata, e[32], e[31:0]);
      end
      n_tests++;
      if (edges !== exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, expected %0d", name, edges, exp_lat);
      end
      n_tests++;
      if (writes !== exp_writes) begin
        n_fail++;
        $display("FAIL %s write strobes: got %0d, expected %0d", name, writes, exp_writes);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (c_ready !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return to idle: ready=%b busy=%b we=%b, expected 0 0 0",
               name, c_ready, busy, mem_we);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({c_ready, d_ready, busy, mem_we, c_err} !== 5'b0 || mem_addr !== '0 ||
        c_rdata !== 32'h0 || d_rdata !== 8'h0 || mem_wdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset outputs: rdy=%b drdy=%b busy=%b we=%b err=%b addr=%h rdata=%h drdata=%h, expected all 0",
               c_ready, d_ready, busy, mem_we, c_err, mem_addr, c_rdata, d_rdata);
    end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_word_store_load;
    core_op(1, 3'b010, 32'h08, 32'hDEADBEEF, {1'b0, 32'h0}, "sw_08", fa);
    n_tests++;
    if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_08 memory: got %h, expected deadbeef",
               {mem[11], mem[10], mem[9], mem[8]});
    end
    core_op(0, 3'b010, 32'h08, 32'h0, {1'b0, 32'hDEADBEEF}, "lw_08", fa);
  endtask

  task automatic test_extension;
    core_op(1, 3'b000, 32'h03, 32'h00000080, {1'b0, 32'h0}, "sb_03", fa);
    core_op(0, 3'b000, 32'h03, 32'h0, {1'b0, 32'hFFFFFF80}, "lb_03", fa);
    core_op(0, 3'b100, 32'h03, 32'h0, {1'b0, 32'h00000080}, "lbu_03", fa);
    core_op(1, 3'b001, 32'h02, 32'h00008001, {1'b0, 32'h0}, "sh_02", fa);
    core_op(0, 3'b001, 32'h02, 32'h0, {1'b0, 32'hFFFF8001}, "lh_02", fa);
    core_op(0, 3'b101, 32'h02, 32'h0, {1'b0, 32'h00008001}, "lhu_02", fa);
  endtask

  task automatic test_errors;
    core_op(0, 3'b010, 32'h06, 32'h0, {1'b1, 32'h0}, "lw_misaligned", fa);
    core_op(0, 3'b011, 32'h00, 32'h0, {1'b1, 32'h0}, "ld_f3_011", fa);
    core_op(1, 3'b100, 32'h00, 32'h12345678, {1'b1, 32'h0}, "st_f3_100", fa);
    core_op(1, 3'b001, 32'h01, 32'h0000ABCD, {1'b1, 32'h0}, "sh_misaligned", fa);
    core_op(0, 3'b101, 32'h03, 32'h0, {1'b1, 32'h0}, "lhu_misaligned", fa);
  endtask

  task automatic test_wrap;
    core_op(1, 3'b000, 32'h40, 32'h0000005A, {1'b0, 32'h0}, "sb_40", fa);
    n_tests++;
    if (fa !== 6'h00) begin
      n_fail++;
      $display("FAIL sb_40 wrap addr: got %h, expected 00", fa);
    end
    core_op(0, 3'b000, 32'h00, 32'h0, {1'b0, 32'h0000005A}, "lb_00", fa);
    core_op(0, 3'b100, 32'hFFFFFF48, 32'h0, {1'b0, 32'h000000EF}, "lbu_high_bits", fa);
    n_tests++;
    if (fa !== 6'h08) begin
      n_fail++;
      $display("FAIL lbu_high_bits addr: got %h, expected 08", fa);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    c_req = 1; c_we = 1; c_funct3 = 3'b010; c_addr = 32'h10; c_wdata = 32'h11223344;
    @(posedge clk);          // granted, XFER k=0
    @(posedge clk); #1;      // XFER k=1
    rst = 1; c_req = 0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || c_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid abort: busy=%b we=%b ready=%b, expected 0 0 0",
               busy, mem_we, c_ready);
    end
    rst = 0;
    bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (c_ready || busy || mem_we) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid quiet: %0d active cycles, expected 0", bad);
    end
    core_op(0, 3'b010, 32'h08, 32'h0, {1'b0, 32'hDEADBEEF}, "lw_after_reset", fa);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    logic [2:0]  f3;
    int off;
    logic [2:0] f3_tab [5];
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
    for (int i = 0; i < 8; i++) begin
      a  = 32'($urandom_range(0, 15)) * 4;
      d  = $urandom;
      core_op(1, 3'b010, a, d, {1'b0, 32'h0}, "rand_sw", fa);
      f3 = f3_tab[$urandom_range(0, 4)];
      case (f3[1:0])
        2'b00:   off = $urandom_range(0, 3);
        2'b01:   off = 2 * $urandom_range(0, 1);
        default: off = 0;
      endcase
      core_op(0, f3, a + 32'(off), 32'h0, {1'b0, ext_model(f3, d >> (8 * off))},
              "rand_ld", fa);
    end
  endtask

`ifdef DMC_DEBUG_PORT_EN
  task automatic dbg_op(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp, input string name);
    int edges;
    logic got;
    logic [32:0] e;
    exp_q.push_back({1'b1, 24'h0, exp});
    @(negedge clk);
    d_req = 1; d_we = we; d_addr = addr; d_wdata = wd;
    edges = 0; got = 0;
    while (!got && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (d_ready) begin got = 1; d_req = 0; end
    end
    e = exp_q.pop_front();
    n_tests++;
    if (!got || edges !== 2 || (!we && d_rdata !== e[7:0])) begin
      n_fail++;
      $display("FAIL %s: ready=%b after %0d cycles rdata=%h, expected ready at 2 rdata=%h",
               name, got, edges, d_rdata, e[7:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_debug_port;
    dbg_op(1, 6'h20, 8'h7E, 8'h00, "dbg_write");
    dbg_op(0, 6'h20, 8'h00, 8'h7E, "dbg_read");
    core_op(0, 3'b000, 32'h20, 32'h0, {1'b0, 32'h0000007E}, "lb_dbg_byte", fa);
  endtask

  task automatic test_arbitration;
    int edges, seen, last_edge;
    logic [32:0] obs, e;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 32'h000000EF});
      exp_q.push_back({1'b1, 24'h0, 8'hBE});
    end
    c_req = 1; c_we = 0; c_funct3 = 3'b100; c_addr = 32'h08;
    d_req = 1; d_we = 0; d_addr = 6'h09;
    edges = 0; seen = 0; last_edge = 0;
    while (seen < 4 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (c_ready || d_ready) begin
        obs = d_ready ? {1'b1, 24'h0, d_rdata} : {1'b0, c_rdata};
        e = exp_q.pop_front();
        n_tests++;
        if (obs !== e || (c_ready && d_ready)) begin
          n_fail++;
          $display("FAIL arb grant %0d: got %h, expected %h", seen, obs, e);
        end
        n_tests++;
        if (edges - last_edge !== (seen == 0 ? 2 : 3)) begin
          n_fail++;
          $display("FAIL arb spacing %0d: got %0d, expected %0d",
                   seen, edges - last_edge, (seen == 0 ? 2 : 3));
        end
        last_edge = edges;
        seen++;
        if (seen == 4) begin c_req = 0; d_req = 0; end
      end
    end
    if (seen < 4) begin
      n_tests++; n_fail++;
      $display("FAIL arb timeout: %0d of 4 responses", seen);
      c_req = 0; d_req = 0;
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_debug_disabled;
    int bad;
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 6'h21; d_wdata = 8'h55;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (d_ready || busy || mem_we || d_rdata != 8'h00) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL dbg_disabled: %0d active cycles, expected 0", bad);
    end
    core_op(0, 3'b100, 32'h08, 32'h0, {1'b0, 32'h000000EF}, "lbu_with_dreq", fa);
    d_req = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_word_store_load;
`ifdef DMC_DEBUG_PORT_EN
    test_arbitration;
    test_debug_port;
`else
    test_debug_disabled;
`endif
    test_extension;
    test_errors;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
